instr_fetch_unit: RTL and testbench

- Producer end of the controller's instruction-field interface.
- Fetches 32-bit ARM instruction words from instruction memory over a req/ack handshake.
- Buffers the words in a small prefetch FIFO and presents the head word to decode, with cond/op/funct/rd pre-sliced and the matching PC and PC+8.
- Consumes branch redirects (taken pc_src plus target): flushes buffered words and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/instr_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and field positions for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned COND_LSB       = 28;
    localparam int unsigned OP_LSB         = 26;
    localparam int unsigned FUNCT_LSB      = 20;
    localparam int unsigned RD_LSB         = 12;
    localparam int unsigned PC_STEP        = 4;
    localparam int unsigned PC_READ_OFFSET = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    // Word-align a fetch address.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] a);
        return {a[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Prefetch FIFO holding fetched words with their PCs; flush wins over push.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output fetch_entry_t       head
);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack memory fetch, prefetch buffering, redirect flush.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirect_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] instr_pc,
    output logic [INSTR_W-1:0] instr_pc_plus8,
    output logic [3:0]         cond,
    output logic [1:0]         op,
    output logic [5:0]         funct,
    output logic [3:0]         rd
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] fetch_pc_q, fetch_pc_d;

    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_next;
    logic               fifo_full;
    logic               fifo_empty;
    fetch_entry_t       fifo_head;
    fetch_entry_t       push_data;
    logic               complete;
    logic               push;
    logic               pop;

    assign complete    = req_q & imem_ack;
    assign push        = (state_q == REQ) & complete & ~redirect;
    assign instr_valid = ~fifo_empty;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign count_next  = redirect ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));
    assign push_data   = '{pc: req_addr_q, word: imem_rdata};

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            req_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Next-state: redirect outranks push, pop and the full stall.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;

        if (redirect)  fetch_pc_d = align_pc(redirect_target);
        else if (push) fetch_pc_d = fetch_pc_q + INSTR_W'(PC_STEP);

        case (state_q)
            IDLE: begin
                if (redirect || !fifo_full) state_d = REQ;
            end
            REQ: begin
                if (redirect)      state_d = complete ? REQ : DISCARD;
                else if (complete) state_d = (count_next < CNT_W'(DEPTH)) ? REQ : IDLE;
            end
            DISCARD: begin
                if (complete) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // A fresh request latches the address it will hold until ack.
        if (state_d == REQ && (state_q != REQ || complete)) req_addr_d = fetch_pc_d;

        req_d = (state_d != IDLE);
    end

    assign imem_req       = req_q;
    assign imem_addr      = req_addr_q;
    assign instr          = instr_valid ? fifo_head.word : '0;
    assign instr_pc       = instr_valid ? fifo_head.pc : '0;
    assign instr_pc_plus8 = instr_valid ? (fifo_head.pc + INSTR_W'(PC_READ_OFFSET)) : '0;
    assign cond           = instr[COND_LSB +: 4];
    assign op             = instr[OP_LSB +: 2];
    assign funct          = instr[FUNCT_LSB +: 6];
    assign rd             = instr[RD_LSB +: 4];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus8;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int comp_cnt = 0;
    int mem_cnt  = 0;
    logic [63:0] exp_q[$];

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus8 (instr_pc_plus8),
        .cond           (cond),
        .op             (op),
        .funct          (funct),
        .rd             (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hE2811005 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory: ack after lat idle cycles of an asserted request.
    always @(negedge clk) begin
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            mem_cnt  = 0;
        end else if (mem_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_cnt    = 0;
            comp_cnt   = comp_cnt + 1;
        end else begin
            imem_ack = 1'b0;
            mem_cnt  = mem_cnt + 1;
        end
    end

    // Monitor: every word decode accepts must match the scoreboard head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && instr_valid && instr_ready && !redirect) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_unexpected: got pc=%h word=%h, required none", instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e[63:32] || instr !== e[31:0] || instr_pc_plus8 !== e[63:32] + 32'd8) begin
                    bad = bad + 1;
                    $display("FAIL sb_word: got pc=%h word=%h pc8=%h, required pc=%h word=%h pc8=%h",
                             instr_pc, instr, instr_pc_plus8, e[63:32], e[31:0], e[63:32] + 32'd8);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total = total + 1;
        if (got !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            logic [31:0] pc;
            pc = start + 32'(4 * i);
            exp_q.push_back({pc, mem_word(pc)});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        load_exp(32'h0);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        bit found;
        reset = 1'b1; redirect = 1'b0; redirect_target = '0;
        instr_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0; lat = 0;

        // Reset state
        do_reset();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_pc8", instr_pc_plus8, 32'h0);

        // Zero-latency streaming with decode always ready
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("a_req", 32'(imem_req), 32'd1);
            chk("a_addr", imem_addr, 32'(4 * k));
            chk("a_valid", 32'(instr_valid), (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) begin
                chk("a_pc", instr_pc, 32'(4 * (k - 1)));
                chk("a_pc8", instr_pc_plus8, 32'(4 * (k - 1) + 8));
            end
            if (k == 1) begin
                chk("a_cond", 32'(cond), 32'hE);
                chk("a_op", 32'(op), 32'h0);
                chk("a_funct", 32'(funct), 32'h28);
                chk("a_rd", 32'(rd), 32'h1);
            end
        end

        // Fill with decode stalled: four completions, then request drops
        instr_ready = 1'b0;
        do_reset();
        base = comp_cnt;
        repeat (5) tick();
        chk("b_req_full", 32'(imem_req), 32'd0);
        chk("b_completions", 32'(comp_cnt - base), 32'd4);
        chk("b_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        chk("b_req_idle3", 32'(imem_req), 32'd0);
        chk("b_pc_after_pop", instr_pc, 32'h4);

        // Redirect from idle with three buffered entries
        instr_ready = 1'b0;
        redirect = 1'b1;
        redirect_target = 32'h103;
        load_exp(32'h100);
        tick();
        redirect = 1'b0;
        chk("c_valid_flush", 32'(instr_valid), 32'd0);
        chk("c_instr_flush", instr, 32'h0);
        chk("c_req", 32'(imem_req), 32'd1);
        chk("c_addr", imem_addr, 32'h100);
        tick();
        chk("c_valid", 32'(instr_valid), 32'd1);
        chk("c_pc", instr_pc, 32'h100);
        repeat (3) tick();
        chk("c_req_full", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        tick();
        chk("c_req_after_pop", 32'(imem_req), 32'd0);
        chk("c_pc_after_pop", instr_pc, 32'h104);
        tick();
        chk("c_restart_req", 32'(imem_req), 32'd1);
        chk("c_restart_addr", imem_addr, 32'h110);

        // Redirect while a slow request is outstanding
        lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        chk("d_found_req10", 32'(found), 32'd1);
        redirect = 1'b1;
        redirect_target = 32'h200;
        load_exp(32'h200);
        tick();
        redirect = 1'b0;
        chk("d_valid_flush", 32'(instr_valid), 32'd0);
        chk("d_req_hold", 32'(imem_req), 32'd1);
        chk("d_addr_hold", imem_addr, 32'h10);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("d_addr_hold", imem_addr, 32'h10);
        end
        tick();
        chk("d_addr_target", imem_addr, 32'h200);
        chk("d_valid_dropped", 32'(instr_valid), 32'd0);
        repeat (4) tick();
        chk("d_valid", 32'(instr_valid), 32'd1);
        chk("d_pc", instr_pc, 32'h200);

        // Reset while discarding
        redirect = 1'b1;
        redirect_target = 32'h300;
        load_exp(32'h0);
        tick();
        redirect = 1'b0;
        reset = 1'b1;
        tick();
        chk("e_req_rst", 32'(imem_req), 32'd0);
        chk("e_valid_rst", 32'(instr_valid), 32'd0);
        reset = 1'b0;
        tick();
        chk("e_req", 32'(imem_req), 32'd1);
        chk("e_addr", imem_addr, 32'h0);
        repeat (4) tick();
        chk("e_valid", 32'(instr_valid), 32'd1);
        chk("e_pc", instr_pc, 32'h0);
        chk("e_instr", instr, 32'hE2811005);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule
